// File: rtl/pwm_capture.sv
// Input-capture unit: measures period and active time of an external pulse train
// in prescaled ticks, with CCR control/status readback and level interrupts.
module pwm_capture #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ccr_we,
    input  logic [WIDTH-1:0] data_in,
    input  logic             cap_in,
    output logic [WIDTH-1:0] o_ccr,
    output logic [WIDTH-1:0] o_cnt,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             int_cap,
    output logic             int_ovf
);

    // CCR field positions reach bit 18; narrower instances simply drop the high fields.
    localparam int CW = (WIDTH > 19) ? WIDTH : 19;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        INACTIVE = 2'd2
    } state_e;

    state_e state, state_next;

    logic             en, pol, capie, ovfie;
    logic [2:0]       prescale;
    logic             capf, ovf, valid;
    logic             sync1, sync2, hist;
    logic [6:0]       pre_cnt, pre_next, pre_max;
    logic [WIDTH-1:0] cnt, cnt_next, cnt_inc;
    logic [WIDTH-1:0] period, period_next, high, high_next;
    logic             set_capf, set_ovf, set_valid;

    logic [CW-1:0] wd;
    logic          w_en, w_pol, w_capie, w_ovfie, w_clr;
    logic [2:0]    w_pre;
    logic          clr_wr, disable_wr, rearm_wr, force_idle;
    logic          rise, fall, start_edge, end_edge, tick, wrap;
    logic          unused_bits;
    logic [CW-1:0] ccr_rd;

    assign wd          = CW'(data_in);
    assign w_en        = wd[0];
    assign w_pol       = wd[1];
    assign w_capie     = wd[2];
    assign w_ovfie     = wd[3];
    assign w_clr       = wd[4];
    assign w_pre       = wd[10:8];
    assign unused_bits = ^{wd[CW-1:11], wd[7:5]};

    assign clr_wr     = ccr_we & w_clr;
    assign disable_wr = ccr_we & ~w_en;
    assign rearm_wr   = ccr_we & en & ((w_pol != pol) | (w_pre != prescale));
    assign force_idle = disable_wr | rearm_wr;

    assign rise       = sync2 & ~hist;
    assign fall       = ~sync2 & hist;
    assign start_edge = pol ? fall : rise;
    assign end_edge   = pol ? rise : fall;

    assign pre_max = 7'((7'd1 << prescale) - 7'd1);
    assign tick    = (pre_cnt == pre_max);
    assign wrap    = tick & (cnt == '1);
    // Captured values include the tick landing on the capturing edge itself.
    assign cnt_inc = tick ? cnt + WIDTH'(1) : cnt;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pre_next    = pre_cnt;
        period_next = period;
        high_next   = high;
        set_capf    = 1'b0;
        set_ovf     = 1'b0;
        set_valid   = 1'b0;
        if (force_idle) begin
            state_next = IDLE;
            cnt_next   = '0;
            pre_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = '0;
                    pre_next = '0;
                    if (en && start_edge) state_next = ACTIVE;
                end
                ACTIVE, INACTIVE: begin
                    cnt_next = cnt_inc;
                    pre_next = tick ? 7'd0 : pre_cnt + 7'd1;
                    if (wrap) begin
                        set_ovf    = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                        pre_next   = '0;
                    end else if (state == ACTIVE && end_edge) begin
                        high_next  = cnt_inc;
                        state_next = INACTIVE;
                    end else if (state == INACTIVE && start_edge) begin
                        period_next = cnt_inc;
                        set_capf    = 1'b1;
                        set_valid   = 1'b1;
                        cnt_next    = '0;
                        pre_next    = '0;
                        state_next  = ACTIVE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    pre_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            hist     <= 1'b0;
            cnt      <= '0;
            pre_cnt  <= '0;
            period   <= '0;
            high     <= '0;
            en       <= 1'b0;
            pol      <= 1'b0;
            capie    <= 1'b0;
            ovfie    <= 1'b0;
            prescale <= '0;
            capf     <= 1'b0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            sync1   <= cap_in;
            sync2   <= sync1;
            hist    <= sync2;
            cnt     <= cnt_next;
            pre_cnt <= pre_next;
            period  <= period_next;
            high    <= high_next;
            if (ccr_we) begin
                en       <= w_en;
                pol      <= w_pol;
                capie    <= w_capie;
                ovfie    <= w_ovfie;
                prescale <= w_pre;
            end
            // A flag being set on the same edge as a CLR write stays set.
            capf <= set_capf | (capf & ~clr_wr);
            ovf  <= set_ovf | (ovf & ~clr_wr);
            if (set_valid) valid <= 1'b1;
            else if (disable_wr) valid <= 1'b0;
        end
    end

    always_comb begin
        ccr_rd       = '0;
        ccr_rd[0]    = en;
        ccr_rd[1]    = pol;
        ccr_rd[2]    = capie;
        ccr_rd[3]    = ovfie;
        ccr_rd[10:8] = prescale;
        ccr_rd[16]   = capf;
        ccr_rd[17]   = ovf;
        ccr_rd[18]   = valid;
    end

    assign o_ccr    = ccr_rd[WIDTH-1:0];
    assign o_cnt    = cnt;
    assign o_period = period;
    assign o_high   = high;
    assign int_cap  = capf & capie;
    assign int_ovf  = ovf & ovfie;

endmodule
